// File: rtl/ram_sp_param.sv
// Parametrised single-port synchronous RAM with a post-reset clear sequence,
// selectable read-during-write behaviour, read-valid strobe and range check.
module ram_sp_param #(
    parameter int unsigned       DATA_W   = 8,
    parameter int unsigned       ADDR_W   = 8,
    parameter int unsigned       DEPTH    = 256,
    parameter int unsigned       WR_MODE  = 0,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic              WE,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] Din,
    output logic [DATA_W-1:0] Dout,
    output logic              Valid,
    output logic              Busy,
    output logic              Err
);

    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_next;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              in_range;
    logic              access;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    // Extra top bit keeps the compare exact when DEPTH == 2**ADDR_W.
    assign in_range = {1'b0, Addr} < DEPTH_X;
    assign access   = EN && (state == RUN);
    assign Busy     = (state == CLEAR);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        mem_we     = 1'b0;
        mem_addr   = Addr;
        mem_wdata  = Din;
        unique case (state)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_addr  = ptr;
                mem_wdata = INIT_VAL;
                ptr_next  = ptr + 1'b1;
                if (ptr == LAST) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                mem_we = EN && WE && in_range;
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    // Storage has no reset so it can map onto block RAM.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Dout  <= '0;
            Valid <= 1'b0;
            Err   <= 1'b0;
        end else begin
            Valid <= 1'b0;
            Err   <= 1'b0;
            if (access) begin
                if (!in_range) begin
                    Dout <= '0;
                    Err  <= 1'b1;
                end else if (!WE) begin
                    Dout  <= mem[Addr];
                    Valid <= 1'b1;
                end else if (WR_MODE == 1) begin
                    Dout  <= Din;
                    Valid <= 1'b1;
                end else if (WR_MODE == 0) begin
                    Dout  <= mem[Addr];
                    Valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_sp_param.sv
// Bench for ram_sp_param: four parameter sets checked against an array model
// of the RAM, clear counter and read-during-write rules.
module tb_ram_sp_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0;
    logic        en = 1'b0, we = 1'b0;
    logic [7:0]  addr = '0, din = '0;
    logic        d_en = 1'b0, d_we = 1'b0;
    logic [3:0]  d_addr = '0;
    logic [15:0] d_din = '0;

    logic [7:0]  dout0, dout1, dout2;
    logic [15:0] dout3;
    logic [3:0]  valid, busy, err;
    logic [15:0] a_dout [4];

    assign a_dout[0] = {8'h00, dout0};
    assign a_dout[1] = {8'h00, dout1};
    assign a_dout[2] = {8'h00, dout2};
    assign a_dout[3] = dout3;

    ram_sp_param u0 (
        .CLK(clk), .RST(rst), .EN(en), .WE(we), .Addr(addr), .Din(din),
        .Dout(dout0), .Valid(valid[0]), .Busy(busy[0]), .Err(err[0])
    );

    ram_sp_param #(.WR_MODE(1), .INIT_VAL(8'hA5)) u1 (
        .CLK(clk), .RST(rst), .EN(en), .WE(we), .Addr(addr), .Din(din),
        .Dout(dout1), .Valid(valid[1]), .Busy(busy[1]), .Err(err[1])
    );

    ram_sp_param #(.WR_MODE(2), .DEPTH(200)) u2 (
        .CLK(clk), .RST(rst), .EN(en), .WE(we), .Addr(addr), .Din(din),
        .Dout(dout2), .Valid(valid[2]), .Busy(busy[2]), .Err(err[2])
    );

    ram_sp_param #(.DATA_W(16), .ADDR_W(4), .DEPTH(16)) u3 (
        .CLK(clk), .RST(rst), .EN(d_en), .WE(d_we), .Addr(d_addr), .Din(d_din),
        .Dout(dout3), .Valid(valid[3]), .Busy(busy[3]), .Err(err[3])
    );

    int          depth [4] = '{256, 256, 200, 16};
    int          mode  [4] = '{0, 1, 2, 0};
    logic [15:0] initv [4] = '{16'h0000, 16'h00A5, 16'h0000, 16'h0000};
    logic [15:0] m     [4][256];
    int          cnt   [4];
    logic [15:0] e_dout  [4];
    logic        e_valid [4];
    logic        e_busy  [4];
    logic        e_err   [4];
    int          checks   = 0;
    int          failures = 0;

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            cnt[k]     = depth[k];
            e_dout[k]  = '0;
            e_valid[k] = 1'b0;
            e_busy[k]  = 1'b1;
            e_err[k]   = 1'b0;
        end
    endtask

    task automatic model_step(input int k, input logic s_en, input logic s_we,
                              input int s_addr, input logic [15:0] s_din);
        if (rst) begin
            return;
        end
        e_valid[k] = 1'b0;
        e_err[k]   = 1'b0;
        if (cnt[k] > 0) begin
            m[k][depth[k] - cnt[k]] = initv[k];
            cnt[k]--;
        end else if (s_en) begin
            if (s_addr >= depth[k]) begin
                e_dout[k] = '0;
                e_err[k]  = 1'b1;
            end else if (!s_we) begin
                e_dout[k]  = m[k][s_addr];
                e_valid[k] = 1'b1;
            end else begin
                if (mode[k] == 0) e_dout[k] = m[k][s_addr];
                if (mode[k] == 1) e_dout[k] = s_din;
                e_valid[k]     = (mode[k] != 2);
                m[k][s_addr]   = s_din;
            end
        end
        e_busy[k] = (cnt[k] != 0);
    endtask

    task automatic cycle();
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            model_step(k, en, we, int'(addr), {8'h00, din});
        end
        model_step(3, d_en, d_we, int'(d_addr), d_din);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (a_dout[k] !== 16'h0 || valid[k] !== 1'b0 ||
                err[k] !== 1'b0 || busy[k] !== 1'b1) begin
                failures++;
                $display("FAIL reset u%0d dout=%h v=%b e=%b b=%b need 0/0/0/1",
                         k, a_dout[k], valid[k], err[k], busy[k]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_clear();
        int first0 [4] = '{0, 0, 0, 0};
        for (int n = 1; n <= 300; n++) begin
            en   = (cnt[0] > 0) ? 1'($urandom) : 1'b0;
            we   = 1'($urandom);
            addr = 8'($urandom);
            din  = 8'($urandom);
            d_en   = (cnt[3] > 0) ? 1'($urandom) : 1'b0;
            d_we   = 1'($urandom);
            d_addr = 4'($urandom);
            d_din  = 16'($urandom);
            cycle();
            for (int k = 0; k < 4; k++) begin
                if (first0[k] == 0 && busy[k] === 1'b0) first0[k] = n;
                checks++;
                if (a_dout[k] !== e_dout[k] || valid[k] !== e_valid[k] ||
                    busy[k] !== e_busy[k] || err[k] !== e_err[k]) begin
                    failures++;
                    $display("FAIL clear u%0d edge %0d dout=%h/%h v=%b/%b b=%b/%b e=%b/%b",
                             k, n, a_dout[k], e_dout[k], valid[k], e_valid[k],
                             busy[k], e_busy[k], err[k], e_err[k]);
                end
            end
        end
        en   = 1'b0;
        d_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (first0[k] != depth[k]) begin
                failures++;
                $display("FAIL clear_len u%0d edges=%0d need %0d", k, first0[k], depth[k]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            en   = 1'b1;
            we   = 1'b0;
            addr = (i == 0) ? 8'd0 : (i == 1) ? 8'd128 : 8'd255;
            cycle();
            checks++;
            if (dout0 !== 8'h00 || valid[0] !== 1'b1) begin
                failures++;
                $display("FAIL clear_read addr=%0d dout=%h v=%b need 00/1", addr, dout0, valid[0]);
            end
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (a_dout[k] !== e_dout[k] || valid[k] !== e_valid[k] ||
                    busy[k] !== e_busy[k] || err[k] !== e_err[k]) begin
                    failures++;
                    $display("FAIL clear_read u%0d dout=%h/%h v=%b/%b b=%b/%b e=%b/%b",
                             k, a_dout[k], e_dout[k], valid[k], e_valid[k],
                             busy[k], e_busy[k], err[k], e_err[k]);
                end
            end
        end
        en = 1'b0;
    endtask

    task automatic test_mid_clear();
        int edges = 0;
        rst = 1'b1;
        model_reset();
        #1;
        rst = 1'b0;
        for (int n = 0; n < 100; n++) cycle();
        rst = 1'b1;
        model_reset();
        #1;
        rst = 1'b0;
        for (int n = 1; n <= 400 && edges == 0; n++) begin
            cycle();
            if (busy[1] === 1'b0) edges = n;
        end
        checks++;
        if (edges != 256) begin
            failures++;
            $display("FAIL mid_clear_len edges=%0d need 256", edges);
        end
        for (int i = 0; i < 20; i++) begin
            en   = 1'b1;
            we   = 1'b0;
            addr = 8'($urandom);
            cycle();
            checks++;
            if (dout1 !== 8'hA5 || valid[1] !== 1'b1) begin
                failures++;
                $display("FAIL mid_clear_read addr=%0d dout=%h v=%b need a5/1", addr, dout1, valid[1]);
            end
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (a_dout[k] !== e_dout[k] || valid[k] !== e_valid[k] ||
                    busy[k] !== e_busy[k] || err[k] !== e_err[k]) begin
                    failures++;
                    $display("FAIL mid_clear u%0d dout=%h/%h v=%b/%b b=%b/%b e=%b/%b",
                             k, a_dout[k], e_dout[k], valid[k], e_valid[k],
                             busy[k], e_busy[k], err[k], e_err[k]);
                end
            end
        end
        en = 1'b0;
    endtask

    task automatic test_en_toggle();
        logic [7:0] want;
        for (int i = 1; i <= 10; i++) begin
            en   = 1'(i % 2);
            we   = 1'b1;
            addr = 8'(i - 1);
            din  = 8'(i);
            cycle();
        end
        for (int j = 0; j < 10; j++) begin
            en   = 1'b1;
            we   = 1'b0;
            addr = 8'(j);
            want = (j % 2 == 0) ? 8'(j + 1) : 8'h00;
            cycle();
            checks++;
            if (dout0 !== want || valid[0] !== 1'b1) begin
                failures++;
                $display("FAIL en_read addr=%0d dout=%h v=%b need %h/1", j, dout0, valid[0], want);
            end
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (a_dout[k] !== e_dout[k] || valid[k] !== e_valid[k] ||
                    busy[k] !== e_busy[k] || err[k] !== e_err[k]) begin
                    failures++;
                    $display("FAIL en_toggle u%0d dout=%h/%h v=%b/%b b=%b/%b e=%b/%b",
                             k, a_dout[k], e_dout[k], valid[k], e_valid[k],
                             busy[k], e_busy[k], err[k], e_err[k]);
                end
            end
            en   = 1'b0;
            addr = 8'($urandom);
            cycle();
            checks++;
            if (dout0 !== want || valid[0] !== 1'b0) begin
                failures++;
                $display("FAIL en_hold addr=%0d dout=%h v=%b need %h/0", j, dout0, valid[0], want);
            end
        end
    endtask

    task automatic test_rdw();
        logic [7:0] prev;
        en   = 1'b1;
        we   = 1'b1;
        addr = 8'd3;
        din  = 8'h03;
        cycle();
        din  = 8'h55;
        prev = dout2;
        cycle();
        checks++;
        if (dout0 !== 8'h03 || valid[0] !== 1'b1) begin
            failures++;
            $display("FAIL rdw_mode0 dout=%h v=%b need 03/1", dout0, valid[0]);
        end
        checks++;
        if (dout1 !== 8'h55 || valid[1] !== 1'b1) begin
            failures++;
            $display("FAIL rdw_mode1 dout=%h v=%b need 55/1", dout1, valid[1]);
        end
        checks++;
        if (dout2 !== prev || valid[2] !== 1'b0) begin
            failures++;
            $display("FAIL rdw_mode2 dout=%h v=%b need %h/0", dout2, valid[2], prev);
        end
        we = 1'b0;
        cycle();
        checks++;
        if (dout0 !== 8'h55 || dout1 !== 8'h55 || dout2 !== 8'h55) begin
            failures++;
            $display("FAIL rdw_readback got %h %h %h need 55", dout0, dout1, dout2);
        end
        en = 1'b0;
    endtask

    task automatic test_oor();
        en   = 1'b1;
        we   = 1'b1;
        addr = 8'd210;
        din  = 8'h77;
        cycle();
        checks++;
        if (err[2] !== 1'b1 || valid[2] !== 1'b0) begin
            failures++;
            $display("FAIL oor_write err=%b v=%b need 1/0", err[2], valid[2]);
        end
        en = 1'b0;
        cycle();
        checks++;
        if (err[2] !== 1'b0) begin
            failures++;
            $display("FAIL oor_pulse err=%b need 0", err[2]);
        end
        en = 1'b1;
        we = 1'b0;
        cycle();
        checks++;
        if (dout2 !== 8'h00 || err[2] !== 1'b1 || valid[2] !== 1'b0) begin
            failures++;
            $display("FAIL oor_read dout=%h err=%b v=%b need 00/1/0", dout2, err[2], valid[2]);
        end
        addr = 8'd10;
        cycle();
        checks++;
        if (dout2 === 8'h77 || a_dout[2] !== e_dout[2] || valid[2] !== 1'b1) begin
            failures++;
            $display("FAIL oor_nowrap dout=%h v=%b need %h/1", dout2, valid[2], e_dout[2]);
        end
        en = 1'b0;
    endtask

    task automatic test_wide();
        d_en   = 1'b1;
        d_we   = 1'b1;
        d_addr = 4'd15;
        d_din  = 16'hFFFF;
        cycle();
        d_addr = 4'd0;
        d_din  = 16'h8001;
        cycle();
        d_we   = 1'b0;
        d_addr = 4'd15;
        cycle();
        checks++;
        if (dout3 !== 16'hFFFF || valid[3] !== 1'b1) begin
            failures++;
            $display("FAIL wide_15 dout=%h v=%b need ffff/1", dout3, valid[3]);
        end
        d_addr = 4'd0;
        cycle();
        checks++;
        if (dout3 !== 16'h8001 || valid[3] !== 1'b1) begin
            failures++;
            $display("FAIL wide_0 dout=%h v=%b need 8001/1", dout3, valid[3]);
        end
        d_en = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            en     = ($urandom_range(0, 3) != 0);
            we     = 1'($urandom);
            addr   = 8'($urandom);
            din    = 8'($urandom);
            d_en   = ($urandom_range(0, 3) != 0);
            d_we   = 1'($urandom);
            d_addr = 4'($urandom);
            d_din  = 16'($urandom);
            cycle();
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (a_dout[k] !== e_dout[k] || valid[k] !== e_valid[k] ||
                    busy[k] !== e_busy[k] || err[k] !== e_err[k]) begin
                    failures++;
                    $display("FAIL random u%0d cyc %0d dout=%h/%h v=%b/%b b=%b/%b e=%b/%b",
                             k, n, a_dout[k], e_dout[k], valid[k], e_valid[k],
                             busy[k], e_busy[k], err[k], e_err[k]);
                end
            end
        end
        en   = 1'b0;
        d_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clear();
        test_mid_clear();
        test_en_toggle();
        test_rdw();
        test_oor();
        test_wide();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
